// File: rtl/tlb_cam_param.sv
// Parametrised MIPS32 TLB CAM: two lookup ports, indexed access, flush sweep and Random/Wired index.
// Latency: lookups combinational (REG_OUT=0) or one cycle (REG_OUT=1); flush takes ENTRIES cycles.
// Backpressure: none; while busy, lookups miss and idx_write is dropped and flagged on write_drop.
module tlb_cam_param #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] idx_index,
    input  logic             idx_write,
    input  logic [18:0]      idx_vpn2,
    input  logic [15:0]      idx_mask,
    input  logic [7:0]       idx_asid,
    input  logic             idx_g,
    output logic [18:0]      idx_vpn2_out,
    output logic [15:0]      idx_mask_out,
    output logic [7:0]       idx_asid_out,
    output logic             idx_g_out,
    output logic             idx_valid_out,
    input  logic [19:0]      vpn_a,
    input  logic [19:0]      vpn_b,
    input  logic [7:0]       asid_a,
    input  logic [7:0]       asid_b,
    output logic             hit_a,
    output logic             hit_b,
    output logic [IDX_W-1:0] index_a,
    output logic [IDX_W-1:0] index_b,
    output logic             oddpage_a,
    output logic             oddpage_b,
    output logic [15:0]      mask_a,
    output logic [15:0]      mask_b,
    output logic             multihit_a,
    output logic             multihit_b,
    input  logic             flush_req,
    input  logic             flush_asid_only,
    input  logic [7:0]       flush_asid,
    output logic             busy,
    output logic             flush_done,
    output logic             write_drop,
    input  logic             random_tick,
    input  logic [IDX_W-1:0] wired,
    input  logic             wired_write,
    output logic [IDX_W-1:0] random_index
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    typedef struct packed {
        logic             hit;
        logic             multihit;
        logic [IDX_W-1:0] index;
        logic [15:0]      mask;
        logic             oddpage;
    } lk_t;

    logic [18:0]        ent_vpn2 [ENTRIES];
    logic [15:0]        ent_mask [ENTRIES];
    logic [7:0]         ent_asid [ENTRIES];
    logic [ENTRIES-1:0] ent_g;
    logic [ENTRIES-1:0] ent_valid;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   sweep_cnt;
    logic               fl_asid_only;
    logic [7:0]         fl_asid;
    logic [ENTRIES-1:0] match_a, match_b;
    lk_t                lk_a_c, lk_b_c, lk_a_sel, lk_b_sel, lk_a, lk_b;

    assign busy = (state == SWEEP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_req) state_nxt = SWEEP;
            SWEEP:   if (sweep_cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sweep_cnt    <= '0;
            fl_asid_only <= 1'b0;
            fl_asid      <= '0;
            flush_done   <= 1'b0;
            write_drop   <= 1'b0;
            ent_valid    <= '0;
        end else begin
            state      <= state_nxt;
            flush_done <= (state == SWEEP) && (sweep_cnt == LAST);
            write_drop <= idx_write && busy;
            if (state == IDLE) begin
                sweep_cnt <= '0;
                if (flush_req) begin
                    fl_asid_only <= flush_asid_only;
                    fl_asid      <= flush_asid;
                end
                if (idx_write) ent_valid[idx_index] <= 1'b1;
            end else begin
                sweep_cnt <= sweep_cnt + IDX_W'(1);
                if (!fl_asid_only || (!ent_g[sweep_cnt] && ent_asid[sweep_cnt] == fl_asid))
                    ent_valid[sweep_cnt] <= 1'b0;
            end
        end
    end

    // Entry payload is deliberately left unreset; only the valid bits matter after reset.
    always_ff @(posedge clock) begin
        if (idx_write && !busy) begin
            ent_vpn2[idx_index] <= idx_vpn2;
            ent_mask[idx_index] <= idx_mask;
            ent_asid[idx_index] <= idx_asid;
            ent_g[idx_index]    <= idx_g;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            random_index <= LAST;
        else if (wired_write)
            random_index <= LAST;
        else if (random_tick)
            random_index <= (random_index <= wired) ? LAST : random_index - IDX_W'(1);
    end

    assign idx_vpn2_out  = ent_vpn2[idx_index];
    assign idx_mask_out  = ent_mask[idx_index];
    assign idx_asid_out  = ent_asid[idx_index];
    assign idx_g_out     = ent_g[idx_index];
    assign idx_valid_out = ent_valid[idx_index];

    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            match_a[e] = ent_valid[e] && (((vpn_a[19:1] ^ ent_vpn2[e]) & ~{3'b000, ent_mask[e]}) == 19'd0)
                         && (ent_g[e] || ent_asid[e] == asid_a);
            match_b[e] = ent_valid[e] && (((vpn_b[19:1] ^ ent_vpn2[e]) & ~{3'b000, ent_mask[e]}) == 19'd0)
                         && (ent_g[e] || ent_asid[e] == asid_b);
        end
    end

    // Lowest matching entry wins; odd-page bit sits just above the run of low mask ones.
    function automatic lk_t resolve(input logic [ENTRIES-1:0] m, input logic [19:0] vpn);
        lk_t        r;
        int         n;
        logic [4:0] ones;
        logic       run;
        r    = '0;
        n    = 0;
        ones = '0;
        run  = 1'b1;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (m[e]) begin
                n++;
                r.index = IDX_W'(e);
                r.mask  = ent_mask[e];
            end
        end
        r.hit      = (n != 0);
        r.multihit = (n > 1);
        for (int i = 0; i < 16; i++) begin
            if (run && r.mask[i]) ones = ones + 5'd1;
            else run = 1'b0;
        end
        r.oddpage = r.hit && vpn[ones];
        return r;
    endfunction

    assign lk_a_c = resolve(match_a, vpn_a);
    assign lk_b_c = resolve(match_b, vpn_b);

    if (REG_OUT) begin : g_reg
        lk_t lk_a_q, lk_b_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                lk_a_q <= '0;
                lk_b_q <= '0;
            end else begin
                lk_a_q <= lk_a_c;
                lk_b_q <= lk_b_c;
            end
        end
        assign lk_a_sel = lk_a_q;
        assign lk_b_sel = lk_b_q;
    end else begin : g_comb
        assign lk_a_sel = lk_a_c;
        assign lk_b_sel = lk_b_c;
    end

    assign lk_a = busy ? '0 : lk_a_sel;
    assign lk_b = busy ? '0 : lk_b_sel;

    assign hit_a      = lk_a.hit;
    assign multihit_a = lk_a.multihit;
    assign index_a    = lk_a.index;
    assign mask_a     = lk_a.mask;
    assign oddpage_a  = lk_a.oddpage;
    assign hit_b      = lk_b.hit;
    assign multihit_b = lk_b.multihit;
    assign index_b    = lk_b.index;
    assign mask_b     = lk_b.mask;
    assign oddpage_b  = lk_b.oddpage;
endmodule

// File: tb/tb_tlb_cam_param.sv
// Bench for tlb_cam_param: a combinational and a registered instance driven in parallel,
// compared every cycle against a behavioural TLB model, plus literal checks on key scenarios.
module tb_tlb_cam_param;
    localparam int N = 16;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [W-1:0] idx_index = '0, wired = '0;
    logic         idx_write = 0, idx_g = 0, flush_req = 0, flush_asid_only = 0;
    logic         random_tick = 0, wired_write = 0;
    logic [18:0]  idx_vpn2 = '0;
    logic [15:0]  idx_mask = '0;
    logic [7:0]   idx_asid = '0, asid_a = '0, asid_b = '0, flush_asid = '0;
    logic [19:0]  vpn_a = '0, vpn_b = '0;

    logic [1:0][18:0]  idx_vpn2_out;
    logic [1:0][15:0]  idx_mask_out, mask_a, mask_b;
    logic [1:0][7:0]   idx_asid_out;
    logic [1:0]        idx_g_out, idx_valid_out, hit_a, hit_b, oddpage_a, oddpage_b;
    logic [1:0]        multihit_a, multihit_b, busy, flush_done, write_drop;
    logic [1:0][W-1:0] index_a, index_b, random_index;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        tlb_cam_param #(.ENTRIES(N), .IDX_W(W), .REG_OUT(1'(k))) u_dut (
            .clock(clock), .reset_n(reset_n),
            .idx_index(idx_index), .idx_write(idx_write), .idx_vpn2(idx_vpn2),
            .idx_mask(idx_mask), .idx_asid(idx_asid), .idx_g(idx_g),
            .idx_vpn2_out(idx_vpn2_out[k]), .idx_mask_out(idx_mask_out[k]),
            .idx_asid_out(idx_asid_out[k]), .idx_g_out(idx_g_out[k]),
            .idx_valid_out(idx_valid_out[k]),
            .vpn_a(vpn_a), .vpn_b(vpn_b), .asid_a(asid_a), .asid_b(asid_b),
            .hit_a(hit_a[k]), .hit_b(hit_b[k]), .index_a(index_a[k]), .index_b(index_b[k]),
            .oddpage_a(oddpage_a[k]), .oddpage_b(oddpage_b[k]),
            .mask_a(mask_a[k]), .mask_b(mask_b[k]),
            .multihit_a(multihit_a[k]), .multihit_b(multihit_b[k]),
            .flush_req(flush_req), .flush_asid_only(flush_asid_only), .flush_asid(flush_asid),
            .busy(busy[k]), .flush_done(flush_done[k]), .write_drop(write_drop[k]),
            .random_tick(random_tick), .wired(wired), .wired_write(wired_write),
            .random_index(random_index[k])
        );
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          hit;
        bit          multi;
        int          idx;
        logic [15:0] mask;
        bit          odd;
    } res_t;

    logic [18:0] m_vpn2 [N];
    logic [15:0] m_mask [N];
    logic [7:0]  m_asid [N];
    bit          m_g [N];
    bit          m_valid [N];
    bit          m_written [N];
    int          sweep_pos;
    bit          sw_asid_only;
    logic [7:0]  sw_asid;
    bit          m_done, m_drop;
    int          m_rand;
    res_t        reg_exp [2];

    function automatic res_t model_lookup(input logic [19:0] vpn, input logic [7:0] asid);
        res_t r;
        int   cnt;
        int   m;
        bit   ok;
        r   = '{0, 0, 0, 16'h0, 0};
        cnt = 0;
        for (int e = 0; e < N; e++) begin
            ok = m_valid[e];
            for (int i = 0; i < 19; i++)
                if (!(i < 16 && m_mask[e][i]) && vpn[i+1] != m_vpn2[e][i]) ok = 0;
            if (!(m_g[e] || m_asid[e] == asid)) ok = 0;
            if (ok) begin
                if (cnt == 0) begin
                    r.idx  = e;
                    r.mask = m_mask[e];
                end
                cnt++;
            end
        end
        r.hit   = (cnt > 0);
        r.multi = (cnt > 1);
        m = 0;
        while (m < 16 && r.mask[m]) m++;
        r.odd = r.hit && vpn[m];
        return r;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < N; e++) m_valid[e] = 0;
        sweep_pos  = -1;
        m_done     = 0;
        m_drop     = 0;
        m_rand     = N - 1;
        reg_exp[0] = '{0, 0, 0, 16'h0, 0};
        reg_exp[1] = '{0, 0, 0, 16'h0, 0};
    endtask

    initial begin
        res_t ra, rb;
        bit   was_busy;
        for (int e = 0; e < N; e++) m_written[e] = 0;
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                ra       = model_lookup(vpn_a, asid_a);
                rb       = model_lookup(vpn_b, asid_b);
                was_busy = (sweep_pos >= 0);
                m_drop   = idx_write && was_busy;
                m_done   = 0;
                if (was_busy) begin
                    if (!sw_asid_only || (!m_g[sweep_pos] && m_asid[sweep_pos] == sw_asid))
                        m_valid[sweep_pos] = 0;
                    sweep_pos++;
                    if (sweep_pos == N) begin
                        sweep_pos = -1;
                        m_done    = 1;
                    end
                end else begin
                    if (idx_write) begin
                        m_vpn2[idx_index]    = idx_vpn2;
                        m_mask[idx_index]    = idx_mask;
                        m_asid[idx_index]    = idx_asid;
                        m_g[idx_index]       = idx_g;
                        m_valid[idx_index]   = 1;
                        m_written[idx_index] = 1;
                    end
                    if (flush_req) begin
                        sweep_pos    = 0;
                        sw_asid_only = flush_asid_only;
                        sw_asid      = flush_asid;
                    end
                end
                if (wired_write) m_rand = N - 1;
                else if (random_tick) m_rand = (m_rand <= int'(wired)) ? N - 1 : m_rand - 1;
                reg_exp[0] = ra;
                reg_exp[1] = rb;
            end
        end
    end

    task automatic check_port(input int k, input string p, input res_t e, input bit bz,
                              input logic h, input logic mh, input logic [W-1:0] ix,
                              input logic [15:0] mk, input logic od);
        chk(k, {p, "_hit"}, 32'(h), bz ? 32'd0 : 32'(e.hit));
        chk(k, {p, "_multihit"}, 32'(mh), bz ? 32'd0 : 32'(e.multi));
        if (!bz) begin
            if (e.hit) chk(k, {p, "_index"}, 32'(ix), 32'(e.idx));
            chk(k, {p, "_mask"}, 32'(mk), 32'(e.mask));
            chk(k, {p, "_oddpage"}, 32'(od), 32'(e.odd));
        end
    endtask

    // Every-cycle compare against the model, away from the active edge.
    initial begin
        res_t ea, eb;
        bit   bz;
        forever begin
            @(negedge clock);
            bz = (sweep_pos >= 0);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    ea = model_lookup(vpn_a, asid_a);
                    eb = model_lookup(vpn_b, asid_b);
                end else begin
                    ea = reg_exp[0];
                    eb = reg_exp[1];
                end
                check_port(k, "a", ea, bz, hit_a[k], multihit_a[k], index_a[k], mask_a[k], oddpage_a[k]);
                check_port(k, "b", eb, bz, hit_b[k], multihit_b[k], index_b[k], mask_b[k], oddpage_b[k]);
                chk(k, "busy", 32'(busy[k]), 32'(bz));
                chk(k, "flush_done", 32'(flush_done[k]), 32'(m_done));
                chk(k, "write_drop", 32'(write_drop[k]), 32'(m_drop));
                chk(k, "random_index", 32'(random_index[k]), 32'(m_rand));
                chk(k, "idx_valid_out", 32'(idx_valid_out[k]), 32'(m_valid[idx_index]));
                if (m_written[idx_index]) begin
                    chk(k, "idx_vpn2_out", 32'(idx_vpn2_out[k]), 32'(m_vpn2[idx_index]));
                    chk(k, "idx_mask_out", 32'(idx_mask_out[k]), 32'(m_mask[idx_index]));
                    chk(k, "idx_asid_out", 32'(idx_asid_out[k]), 32'(m_asid[idx_index]));
                    chk(k, "idx_g_out", 32'(idx_g_out[k]), 32'(m_g[idx_index]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int idx, input logic [18:0] v, input logic [15:0] m,
                      input logic [7:0] a, input logic g);
        idx_index = W'(idx);
        idx_vpn2  = v;
        idx_mask  = m;
        idx_asid  = a;
        idx_g     = g;
        idx_write = 1;
        step();
        idx_write = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [18:0] e7 = 19'h2B3C0;
    logic [18:0] pool [4] = '{19'h00101, 19'h12345, 19'h2AAAA, 19'h00FF0};
    logic [15:0] masks [5] = '{16'h0000, 16'h0001, 16'h0003, 16'h000F, 16'h00FF};
    logic [7:0]  asids [3] = '{8'h05, 8'h06, 8'h07};

    initial begin
        int         n;
        int         exp_r;
        logic [2:0] v3;
        repeat (3) @(posedge clock);
        #1;
        chk(0, "reset_random", 32'(random_index[0]), 32'd15);
        chk(1, "reset_busy", 32'(busy[1]), 32'd0);
        reset_n = 1;
        step();

        // basic hit, registered latency, ASID miss
        wr(3, 19'h12345, 16'h0000, 8'h05, 1'b0);
        vpn_a  = 20'h2468A;
        asid_a = 8'h05;
        #1;
        chk(0, "t1_hit", 32'(hit_a[0]), 32'd1);
        chk(0, "t1_index", 32'(index_a[0]), 32'd3);
        chk(0, "t1_oddpage", 32'(oddpage_a[0]), 32'd0);
        chk(0, "t1_mask", 32'(mask_a[0]), 32'd0);
        chk(1, "t1_reg_hit_early", 32'(hit_a[1]), 32'd0);
        step();
        chk(1, "t1_reg_hit", 32'(hit_a[1]), 32'd1);
        chk(1, "t1_reg_index", 32'(index_a[1]), 32'd3);
        asid_a = 8'h06;
        #1;
        chk(0, "t1_asid_miss", 32'(hit_a[0]), 32'd0);

        // masked, global entry with odd/even page selection
        wr(7, e7, 16'h0003, 8'h77, 1'b1);
        for (int v = 0; v < 8; v++) begin
            v3     = 3'(v);
            vpn_b  = {e7[18:2], v3};
            asid_b = 8'($urandom);
            #1;
            chk(0, "t2_hit", 32'(hit_b[0]), 32'd1);
            chk(0, "t2_index", 32'(index_b[0]), 32'd7);
            chk(0, "t2_oddpage", 32'(oddpage_b[0]), 32'(v3[2]));
            chk(0, "t2_mask", 32'(mask_b[0]), 32'h3);
            step();
        end

        // multi-hit
        wr(2, 19'h00077, 16'h0000, 8'h10, 1'b0);
        wr(9, 19'h00077, 16'h0000, 8'h10, 1'b0);
        vpn_a  = 20'h000EF;
        asid_a = 8'h10;
        #1;
        chk(0, "t3_hit", 32'(hit_a[0]), 32'd1);
        chk(0, "t3_index", 32'(index_a[0]), 32'd2);
        chk(0, "t3_multihit", 32'(multihit_a[0]), 32'd1);
        chk(0, "t3_single_b", 32'(multihit_b[0]), 32'd0);

        // ASID-selective flush with a write attempted mid-sweep
        wr(4, 19'h11111, 16'h0000, 8'h05, 1'b0);
        wr(5, 19'h22222, 16'h0000, 8'h05, 1'b1);
        wr(6, 19'h33333, 16'h0000, 8'h06, 1'b0);
        flush_asid_only = 1;
        flush_asid      = 8'h05;
        flush_req       = 1;
        step();
        flush_req = 0;
        n = 0;
        while (busy[0] === 1'b1 && n < 64) begin
            n++;
            idx_write = (n == 3);
            idx_index = 4'd6;
            idx_vpn2  = 19'h44444;
            idx_asid  = 8'h09;
            step();
            idx_write = 0;
            if (n == 3) chk(0, "t4_write_drop", 32'(write_drop[0]), 32'd1);
        end
        #1;
        chk(0, "t4_busy_cycles", 32'(n), 32'd16);
        chk(0, "t4_flush_done", 32'(flush_done[0]), 32'd1);
        idx_index = 4'd4; #1; chk(0, "t4_e4_valid", 32'(idx_valid_out[0]), 32'd0);
        idx_index = 4'd5; #1; chk(0, "t4_e5_valid", 32'(idx_valid_out[0]), 32'd1);
        idx_index = 4'd6; #1; chk(0, "t4_e6_valid", 32'(idx_valid_out[0]), 32'd1);
        chk(0, "t4_e6_asid", 32'(idx_asid_out[0]), 32'h06);
        step();

        // Random countdown with Wired floor, then wired_write override
        wired       = 4'd4;
        random_tick = 1;
        for (int i = 0; i < 14; i++) begin
            exp_r = (i <= 11) ? 15 - i : 15 - (i - 12);
            #1;
            chk(0, "t5_random", 32'(random_index[0]), 32'(exp_r));
            step();
        end
        wired_write = 1;
        step();
        wired_write = 0;
        random_tick = 0;
        #1;
        chk(0, "t5_wired_write", 32'(random_index[0]), 32'd15);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            idx_write       = ($urandom_range(0, 3) == 0);
            idx_index       = W'($urandom_range(0, N - 1));
            idx_vpn2        = pool[$urandom_range(0, 3)];
            idx_mask        = masks[$urandom_range(0, 4)];
            idx_asid        = asids[$urandom_range(0, 2)];
            idx_g           = ($urandom_range(0, 4) == 0);
            vpn_a           = {pool[$urandom_range(0, 3)], 1'b0} ^ 20'($urandom_range(0, 511));
            vpn_b           = {pool[$urandom_range(0, 3)], 1'b0} ^ 20'($urandom_range(0, 511));
            asid_a          = asids[$urandom_range(0, 2)];
            asid_b          = asids[$urandom_range(0, 2)];
            flush_req       = ($urandom_range(0, 99) < 2);
            flush_asid_only = 1'($urandom_range(0, 1));
            flush_asid      = asids[$urandom_range(0, 2)];
            random_tick     = 1'($urandom_range(0, 1));
            wired           = W'($urandom_range(0, N - 1));
            wired_write     = ($urandom_range(0, 19) == 0);
            step();
        end
        idx_write   = 0;
        flush_req   = 0;
        random_tick = 0;
        wired_write = 0;
        repeat (20) step();

        // reset asserted in the middle of a global sweep
        wr(1, 19'h00101, 16'h0000, 8'h05, 1'b1);
        flush_asid_only = 0;
        flush_req       = 1;
        step();
        flush_req = 0;
        repeat (5) step();
        reset_n = 0;
        #1;
        chk(0, "t6_busy", 32'(busy[0]), 32'd0);
        chk(1, "t6_busy", 32'(busy[1]), 32'd0);
        chk(1, "t6_reg_hit", 32'(hit_a[1]), 32'd0);
        for (int e = 0; e < N; e++) begin
            idx_index = W'(e);
            #1;
            chk(1, "t6_valid", 32'(idx_valid_out[1]), 32'd0);
        end
        step();
        step();
        reset_n = 1;
        for (int c = 0; c < 24; c++) begin
            step();
            chk(0, "t6_no_done", 32'(flush_done[0]), 32'd0);
            chk(1, "t6_no_done", 32'(flush_done[1]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
